pattern_matcher: RTL

//  Bit-serial pattern matcher. Successor to the fixed 4-bit compare stage in the UART receive path.
//  - Owns its own shift window; takes the deserialised bit stream directly.
//  - Pattern and don't-care mask are run-time loadable.
//  - Runtime-selectable overlapping / non-overlapping detection.
//  - Fill qualification: no match fires before PAT_W valid bits have arrived.
//  - Saturating match counter.

---
 rtl/pattern_matcher_pkg.sv | 15 +
 rtl/pattern_matcher_if.sv | 43 ++++
 rtl/pattern_matcher_defs.vh | 11 +
 rtl/pattern_matcher_shift_window.sv | 66 ++++++
 rtl/pattern_matcher.sv | 86 ++++++++
 5 files changed

// File: rtl/pattern_matcher_pkg.sv
// Package for the pattern matcher: fill phase encoding and shared limits.
`include "pattern_matcher_defs.vh"

package pattern_matcher_pkg;

   // Fill counter phase, exported for debug.
   typedef enum logic {
      PH_FILL  = 1'b0,
      PH_ARMED = 1'b1
   } fill_phase_e;

   localparam int PM_PAT_W_MAX_P = `PM_PAT_W_MAX;
   localparam logic [PM_PAT_W_MAX_P-1:0] PM_PAT_DEFAULT_P = `PM_PAT_DEFAULT;

endpackage

// File: rtl/pattern_matcher_if.sv
// Bus interface of the pattern matcher. Handshake: bit_in is consumed on every
// rising edge where bit_valid is high (no back-pressure); match is a one-cycle
// pulse. Optional irq/irq_clr exist only with PATTERN_MATCHER_IRQ_EN.
interface pattern_matcher_if
   import pattern_matcher_pkg::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             bit_in;
   logic             bit_valid;
   logic             overlap;
   logic             pat_load;
   logic [PAT_W-1:0] pat_in;
   logic [PAT_W-1:0] mask_in;
   logic             cnt_clr;
   logic             match;
   logic [CNT_W-1:0] match_count;
   logic [PAT_W-1:0] window;
   fill_phase_e      phase;
`ifdef PATTERN_MATCHER_IRQ_EN
   logic             irq;
   logic             irq_clr;
`endif

   modport master (
      output bit_in, bit_valid, overlap, pat_load, pat_in, mask_in, cnt_clr,
`ifdef PATTERN_MATCHER_IRQ_EN
      output irq_clr,
      input  irq,
`endif
      input  match, match_count, window, phase
   );

   modport slave (
      input  bit_in, bit_valid, overlap, pat_load, pat_in, mask_in, cnt_clr,
`ifdef PATTERN_MATCHER_IRQ_EN
      input  irq_clr,
      output irq,
`endif
      output match, match_count, window, phase
   );
endinterface

// File: rtl/pattern_matcher_defs.vh
// Shared definitions for the pattern matcher block: widest supported window,
// reset pattern/mask values and the fill-counter width helper.
`ifndef PATTERN_MATCHER_DEFS_VH
`define PATTERN_MATCHER_DEFS_VH

`define PM_PAT_W_MAX       32
`define PM_PAT_DEFAULT     32'h0000_0006
`define PM_MASK_DEFAULT    '1
`define PM_FILL_W(w)       $clog2((w) + 1)

`endif

// File: rtl/pattern_matcher_shift_window.sv
// Shift window and fill counter. The counter counts valid bits up to PAT_W
// (ARMED) and holds there; load or disarm send it back to 0.
`include "pattern_matcher_defs.vh"

module shift_window
   import pattern_matcher_pkg::*;
#(
   parameter int PAT_W = 4
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic             bit_in,
   input  logic             disarm,
   output logic [PAT_W-1:0] window,
   output logic [PAT_W-1:0] next_window,
   output logic             armed_next,
   output fill_phase_e      phase
);
   localparam int FILL_W = `PM_FILL_W(PAT_W);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

   logic [PAT_W-1:0]  win_q;
   logic [FILL_W-1:0] fill_q;
   logic [FILL_W-1:0] fill_inc;
   logic [FILL_W-1:0] fill_d;

   // Next window value and whether this edge completes the fill.
   always_comb begin
      next_window = win_q;
      fill_inc    = fill_q;
      armed_next  = 1'b0;
      if (fill_q != FILL_FULL)
         fill_inc = fill_q + 1'b1;
      if (load) begin
         next_window = '0;
      end else if (shift) begin
         next_window = {win_q[PAT_W-2:0], bit_in};
         armed_next  = (fill_inc == FILL_FULL);
      end
   end

   // Next fill count; a non-overlapping match disqualifies the window.
   always_comb begin
      fill_d = fill_q;
      if (load)
         fill_d = '0;
      else if (shift)
         fill_d = disarm ? '0 : fill_inc;
   end

   // Window and fill registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_q  <= '0;
         fill_q <= '0;
      end else begin
         win_q  <= next_window;
         fill_q <= fill_d;
      end
   end

   assign window = win_q;
   assign phase  = (fill_q == FILL_FULL) ? PH_ARMED : PH_FILL;
endmodule

// File: rtl/pattern_matcher.sv
// Bit-serial pattern matcher: loadable pattern/mask, masked compare on the
// post-shift window, registered match pulse and saturating match counter.
// Optional sticky irq is built when PATTERN_MATCHER_IRQ_EN is defined.
`include "pattern_matcher_defs.vh"

module pattern_matcher
   import pattern_matcher_pkg::*;
#(
   parameter int               PAT_W       = 4,
   parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(`PM_PAT_DEFAULT),
   parameter int               CNT_W       = 8
)(
   input logic clk,
   input logic rst,
   pattern_matcher_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [PAT_W-1:0] pat_q;
   logic [PAT_W-1:0] mask_q;
   logic [PAT_W-1:0] next_window;
   logic             armed_next;
   logic             hit;
   logic             match_d;
   logic             match_q;
   logic [CNT_W-1:0] cnt_q;

   shift_window #(.PAT_W(PAT_W)) u_window (
      .clk         (clk),
      .rst         (rst),
      .load        (bus.pat_load),
      .shift       (bus.bit_valid),
      .bit_in      (bus.bit_in),
      .disarm      (match_d & ~bus.overlap),
      .window      (bus.window),
      .next_window (next_window),
      .armed_next  (armed_next),
      .phase       (bus.phase)
   );

   // Masked compare; armed_next is already low on load or idle cycles.
   always_comb begin
      hit     = (((next_window ^ pat_q) & mask_q) == '0);
      match_d = armed_next & hit;
   end

   // Pattern/mask registers, match pulse and saturating counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         pat_q   <= PAT_DEFAULT;
         mask_q  <= `PM_MASK_DEFAULT;
         match_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         if (bus.pat_load) begin
            pat_q  <= bus.pat_in;
            mask_q <= bus.mask_in;
         end
         match_q <= match_d;
         if (bus.cnt_clr)
            cnt_q <= '0;
         else if (match_d && (cnt_q != CNT_MAX))
            cnt_q <= cnt_q + 1'b1;
      end
   end

   assign bus.match       = match_q;
   assign bus.match_count = cnt_q;

`ifdef PATTERN_MATCHER_IRQ_EN
   logic irq_q;

   // Sticky interrupt; a new match wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst)
         irq_q <= 1'b0;
      else if (match_d)
         irq_q <= 1'b1;
      else if (bus.irq_clr)
         irq_q <= 1'b0;
   end

   assign bus.irq = irq_q;
`else
`endif
endmodule
